aes256_key_schedule_inv_seq: RTL and testbench
==============================================

AES256_KEY_SCHEDULE_INV_SEQ -- requirements
Module: aes256_key_schedule_inv_seq

Interface
REQ-001 SHALL have no parameters; all sizes fixed by AES-256 (256-bit key, 15 round keys of 128 bits).
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request to begin a schedule; sampled only in IDLE.
REQ-005 key_i  input  256  master key; word 0 is key_i[255:224], sampled in the start cycle only.
REQ-006 busy_o  output  1  high from the cycle after start acceptance until done_o.
REQ-007 rk_valid_o  output  1  rk_o and rk_idx_o carry a round key.
REQ-008 rk_ready_i  input  1  consumer accepts a key; a handshake occurs when rk_valid_o and rk_ready_i are both high.
REQ-009 rk_o  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-010 rk_idx_o  output  4  round number r of rk_o (14 down to 0).
REQ-011 done_o  output  1  one-cycle pulse after the round-0 handshake.

Function
REQ-012 Round keys SHALL be delivered in decryption order (r = 14, 13, ... 0), one per handshake, and SHALL be bit-identical to the FIPS-197 AES-256 key expansion.
REQ-013 The state register SHALL hold one 8-word block B_k = w[8k..8k+7], with k in 0..7; w[60..63] are computed and never output.
REQ-014 FSM states SHALL be IDLE, FWD, EMIT_HI and EMIT_LO.
REQ-015 IDLE plus start_i SHALL load B_0 = key_i, set k = 0, and enter FWD.
REQ-016 In FWD, each cycle SHALL apply the forward step B_k to B_k+1, using Rcon[k+1] = 01,02,04,08,10,20,40 and SubWord on the word in block position 3; after 7 cycles (k = 7) the FSM SHALL enter EMIT_HI.
REQ-017 EMIT_HI SHALL present words 0..3 of B_k (r = 2k); EMIT_LO SHALL present words 4..7 of B_{k-1}, computed as the reverse step (r = 2k-1).
REQ-018 The reverse step SHALL use w[i-8] = w[i] xor w[i-1] for ordinary words, and SubWord/RotWord/Rcon[k] for word position 0 and SubWord for position 4.
REQ-019 The register SHALL update from B_k to B_{k-1} on the EMIT_LO handshake.
REQ-020 Sequence at k = 7: HI (r = 14), then LO (r = 13), then k = 6.
REQ-021 For k = 6..1: HI then LO after each reverse step.
REQ-022 The EMIT_HI handshake at k = 0 (r = 0) SHALL return to IDLE and pulse done_o in the next cycle.
REQ-023 With rk_ready_i held high: first key (r = 14) valid in cycle 8 after the start cycle; one key per cycle; r = 0 in cycle 22; done_o in cycle 23.
REQ-024 While rk_valid_o is high and rk_ready_i is low, rk_o and rk_idx_o SHALL hold stable and state SHALL not advance.
REQ-025 start_i asserted while busy_o is high SHALL be ignored.
REQ-026 start_i in the done_o cycle SHALL be accepted, since the FSM is already in IDLE.
REQ-027 rk_valid_o SHALL be low in IDLE and FWD.

Reset
REQ-028 Asserting rst_ni low SHALL immediately force IDLE, k = 0, the block register to zero, and all outputs to zero.
REQ-029 Reset SHALL take effect at any point, including mid-FWD or mid-handshake; no partial key sequence resumes after reset.
REQ-030 The first start SHALL be accepted in the first clock edge after rst_ni deasserts.

Structure
REQ-031 Shared package aes256_pkg SHALL hold the state enum, the Rcon table (index 1..7), and word/round-key widths.
REQ-032 One sub-module SHALL be used: aes_sbox (8-bit combinational S-box).
REQ-033 Exactly 8 aes_sbox instances (two SubWords) SHALL be shared by a mux between the forward and reverse steps.
REQ-034 No other S-box logic SHALL exist in the block.

Verification
REQ-035 Key 000102..1f with ready high: r = 14 is 24fc79ccbf0979e9371ac23c6d68de36 at cycle 8; r = 1 is 101112131415161718191a1b1c1d1e1f; r = 0 is 000102030405060708090a0b0c0d0e0f at cycle 22; done_o at cycle 23.
REQ-036 Key 603deb10..0914dff4 (FIPS-197 A.3): r = 14 is fe4890d1e6188d0b046df344706c631e; all 15 keys match the forward expansion in reverse order.
REQ-037 Backpressure with random rk_ready_i (including low for 5 cycles): rk_o and rk_idx_o stay stable while stalled; sequence and values are unchanged; exactly 15 handshakes occur.
REQ-038 start_i pulsed with a different key during FWD and during EMIT_LO: ignored; output matches the first key.
REQ-039 rst_ni low at the r = 9 stall: outputs are 0 next cycle; a new start then yields a full correct 15-key sequence.
REQ-040 start_i in the done_o cycle: a second schedule begins; its r = 14 appears 8 cycles later.

Source files
------------

// File: rtl/aes256_pkg.sv
// Shared types and constants for the AES-256 inverse-order key schedule.
// A block holds eight 32-bit words, word 0 in the most significant position.
package aes256_pkg;

    localparam int WORD_W = 32;
    localparam int RK_W   = 128;
    localparam int KEY_W  = 256;

    typedef logic [WORD_W-1:0]       word_t;
    typedef logic [0:7][WORD_W-1:0]  block_t;
    typedef logic [0:3][WORD_W-1:0]  half_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FWD     = 2'd1,
        EMIT_HI = 2'd2,
        EMIT_LO = 2'd3
    } state_t;

    // Rcon[1..7]; entry 0 is unused filler so a 3-bit index never leaves the table.
    localparam logic [0:7][7:0] RCON_TBL = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    function automatic word_t rcon_word(input logic [2:0] idx);
        return {RCON_TBL[idx], 24'h000000};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational table lookup.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry for input 0 sits in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TBL[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes256_key_schedule_inv_seq.sv
// AES-256 key schedule emitting round keys 14 down to 0: expands forward to the
// last 8-word block, then walks backward one block per pair of round keys.
module aes256_key_schedule_inv_seq
    import aes256_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [KEY_W-1:0]  key_i,
    output logic              busy_o,
    output logic              rk_valid_o,
    input  logic              rk_ready_i,
    output logic [RK_W-1:0]   rk_o,
    output logic [3:0]        rk_idx_o,
    output logic              done_o
);

    state_t       state_reg, state_next;
    logic [2:0]   k_reg, k_next;
    block_t       blk_reg, blk_next;
    logic         done_reg, done_next;

    word_t        rot_src, sub_in_a, sub_out_a, sub_in_b, sub_out_b;
    half_t        fwd_lo, fwd_hi, rev_lo, rev_hi;
    logic         handshake;

    // Both directions share one SubWord(RotWord) unit (a) and one SubWord unit (b).
    assign rot_src  = (state_reg == FWD) ? blk_reg[7] : (blk_reg[7] ^ blk_reg[6]);
    assign sub_in_a = {rot_src[23:0], rot_src[31:24]};
    assign sub_in_b = (state_reg == FWD) ? fwd_lo[3] : blk_reg[3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox_a (.in_byte(sub_in_a[8*gi +: 8]), .out_byte(sub_out_a[8*gi +: 8]));
            aes_sbox u_sbox_b (.in_byte(sub_in_b[8*gi +: 8]), .out_byte(sub_out_b[8*gi +: 8]));
        end
    endgenerate

    // Forward step B_k -> B_{k+1}.
    assign fwd_lo[0] = blk_reg[0] ^ sub_out_a ^ rcon_word(k_reg + 3'd1);
    assign fwd_lo[1] = blk_reg[1] ^ fwd_lo[0];
    assign fwd_lo[2] = blk_reg[2] ^ fwd_lo[1];
    assign fwd_lo[3] = blk_reg[3] ^ fwd_lo[2];
    assign fwd_hi[0] = blk_reg[4] ^ sub_out_b;
    assign fwd_hi[1] = blk_reg[5] ^ fwd_hi[0];
    assign fwd_hi[2] = blk_reg[6] ^ fwd_hi[1];
    assign fwd_hi[3] = blk_reg[7] ^ fwd_hi[2];

    // Reverse step B_k -> B_{k-1}: w[i-8] = w[i] ^ f(w[i-1]).
    assign rev_hi[3] = blk_reg[7] ^ blk_reg[6];
    assign rev_hi[2] = blk_reg[6] ^ blk_reg[5];
    assign rev_hi[1] = blk_reg[5] ^ blk_reg[4];
    assign rev_hi[0] = blk_reg[4] ^ sub_out_b;
    assign rev_lo[3] = blk_reg[3] ^ blk_reg[2];
    assign rev_lo[2] = blk_reg[2] ^ blk_reg[1];
    assign rev_lo[1] = blk_reg[1] ^ blk_reg[0];
    assign rev_lo[0] = blk_reg[0] ^ sub_out_a ^ rcon_word(k_reg);

    assign rk_valid_o = (state_reg == EMIT_HI) || (state_reg == EMIT_LO);
    assign handshake  = rk_valid_o && rk_ready_i;
    assign busy_o     = (state_reg != IDLE);
    assign done_o     = done_reg;

    always_comb begin
        rk_o     = '0;
        rk_idx_o = 4'd0;
        if (state_reg == EMIT_HI) begin
            rk_o     = blk_reg[0:3];
            rk_idx_o = {k_reg, 1'b0};
        end else if (state_reg == EMIT_LO) begin
            rk_o     = rev_hi;
            rk_idx_o = {k_reg, 1'b0} - 4'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        blk_next   = blk_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    blk_next   = key_i;
                    k_next     = 3'd0;
                    state_next = FWD;
                end
            end
            FWD: begin
                blk_next = {fwd_lo, fwd_hi};
                k_next   = k_reg + 3'd1;
                if (k_reg == 3'd6) begin
                    state_next = EMIT_HI;
                end
            end
            EMIT_HI: begin
                if (handshake) begin
                    if (k_reg == 3'd0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = EMIT_LO;
                    end
                end
            end
            EMIT_LO: begin
                if (handshake) begin
                    blk_next   = {rev_lo, rev_hi};
                    k_next     = k_reg - 3'd1;
                    state_next = EMIT_HI;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            k_reg     <= 3'd0;
            blk_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            blk_reg   <= blk_next;
            done_reg  <= done_next;
        end
    end

endmodule

// File: tb/tb_aes256_key_schedule_inv_seq.sv
// Scoreboard bench: stimulus pushes expected round keys from an independent forward
// expansion model; a negedge monitor pops and compares on every handshake.
module tb_aes256_key_schedule_inv_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         done;

    always #5 clk = ~clk;

    aes256_key_schedule_inv_seq dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .key_i      (key),
        .busy_o     (busy),
        .rk_valid_o (rk_valid),
        .rk_ready_i (rk_ready),
        .rk_o       (rk),
        .rk_idx_o   (rk_idx),
        .done_o     (done)
    );

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] rk;
    } exp_t;

    exp_t       exp_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;
    int         hs_count     = 0;
    logic [7:0] sbox_m [256];

    localparam logic [255:0] K0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K1 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box built from the GF(2^8) inverse and the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
    endfunction

    // Textbook forward expansion; expected keys are queued in decryption order.
    task automatic push_expected(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        exp_t        e;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 14; r >= 0; r--) begin
            e.idx = 4'(r);
            e.rk  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        check(name, 128'(done), 128'(1'b1));
    endtask

    task automatic check_totals(input string name);
        check({name, "_handshakes"}, 128'(hs_count), 128'(15));
        check({name, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic begin_schedule(input logic [255:0] k);
        start = 1'b1;
        key   = k;
        push_expected(k);
        hs_count = 0;
        step();
        start = 1'b0;
    endtask

    // Monitor: scoreboard on handshakes plus hold-stable check during stalls.
    initial begin : monitor
        logic         prev_stall;
        logic [127:0] prev_rk;
        logic [3:0]   prev_idx;
        exp_t         e;
        prev_stall = 1'b0;
        prev_rk    = '0;
        prev_idx   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_rk_stable", rk, prev_rk);
                    check("stall_idx_stable", 128'(rk_idx), 128'(prev_idx));
                end
                if (rk_valid && rk_ready) begin
                    hs_count++;
                    $display("[TB] handshake r=%0d rk=%h", rk_idx, rk);
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_key: got r=%0d %h required no key", rk_idx, rk);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_idx", 128'(rk_idx), 128'(e.idx));
                        check("sb_rk", rk, e.rk);
                    end
                end
                prev_stall = rk_valid && !rk_ready;
                prev_rk    = rk;
                prev_idx   = rk_idx;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int cyc;
        rst_n    = 1'b0;
        start    = 1'b0;
        key      = '0;
        rk_ready = 1'b1;
        build_sbox();
        #12;
        check("reset_busy", 128'(busy), 128'(1'b0));
        check("reset_valid", 128'(rk_valid), 128'(1'b0));
        check("reset_rk", rk, 128'h0);
        check("reset_idx", 128'(rk_idx), 128'(4'd0));
        check("reset_done", 128'(done), 128'(1'b0));

        // Key 00..1f, ready high; start offered with the reset release.
        step();
        rst_n = 1'b1;
        begin_schedule(K0);                                       // now cycle 1
        check("fwd_busy", 128'(busy), 128'(1'b1));
        check("fwd_valid_low", 128'(rk_valid), 128'(1'b0));
        repeat (7) step();                                        // cycle 8
        check("c8_valid", 128'(rk_valid), 128'(1'b1));
        check("c8_idx", 128'(rk_idx), 128'(4'd14));
        check("c8_rk14", rk, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        repeat (13) step();                                       // cycle 21
        check("c21_idx", 128'(rk_idx), 128'(4'd1));
        check("c21_rk1", rk, 128'h101112131415161718191a1b1c1d1e1f);
        step();                                                   // cycle 22
        check("c22_idx", 128'(rk_idx), 128'(4'd0));
        check("c22_rk0", rk, 128'h000102030405060708090a0b0c0d0e0f);
        step();                                                   // cycle 23
        check("c23_done", 128'(done), 128'(1'b1));
        check("c23_busy", 128'(busy), 128'(1'b0));
        check("c23_valid", 128'(rk_valid), 128'(1'b0));
        check_totals("k0");

        // FIPS-197 A.3 key, then a restart in the done cycle.
        step();
        begin_schedule(K1);
        repeat (7) step();
        check("a3_rk14", rk, 128'hfe4890d1e6188d0b046df344706c631e);
        wait_done("a3_done");
        check_totals("a3");
        begin_schedule(K0);
        n = 1;
        while (!rk_valid && n < 20) begin
            step();
            n++;
        end
        check("restart_latency", 128'(n), 128'(8));
        wait_done("restart_done");
        check_totals("restart");

        // Random backpressure with a forced 5-cycle stall.
        step();
        begin_schedule(K1);
        cyc = 0;
        while (!done && cyc < 400) begin
            step();
            rk_ready = (cyc >= 12 && cyc < 17) ? 1'b0 : 1'($urandom_range(0, 1));
            cyc++;
        end
        rk_ready = 1'b1;
        check("bp_done", 128'(done), 128'(1'b1));
        check_totals("bp");

        // start with another key during FWD and during EMIT_LO is ignored.
        step();
        begin_schedule(K0);                                       // cycle 1
        step();
        step();                                                   // cycle 3
        start = 1'b1;
        key   = K1;
        step();
        start = 1'b0;                                             // cycle 4
        repeat (5) step();                                        // cycle 9
        check("ign_lo_idx", 128'(rk_idx), 128'(4'd13));
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ign_done");
        check_totals("ign");

        // Reset while stalled at r = 9, then a fresh schedule.
        step();
        begin_schedule(K1);
        n = 0;
        while (!(rk_valid && rk_idx == 4'd9) && n < 100) begin
            step();
            n++;
        end
        rk_ready = 1'b0;
        check("r9_reached", 128'(rk_idx), 128'(4'd9));
        step();
        check("r9_stalled_idx", 128'(rk_idx), 128'(4'd9));
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 128'(rk_valid), 128'(1'b0));
        check("rst_mid_rk", rk, 128'h0);
        check("rst_mid_idx", 128'(rk_idx), 128'(4'd0));
        check("rst_mid_busy", 128'(busy), 128'(1'b0));
        exp_q.delete();
        step();
        check("rst_next_valid", 128'(rk_valid), 128'(1'b0));
        check("rst_next_done", 128'(done), 128'(1'b0));
        rst_n    = 1'b1;
        rk_ready = 1'b1;
        begin_schedule(K0);
        wait_done("post_rst_done");
        check_totals("post_rst");

        step();
        check("idle_valid", 128'(rk_valid), 128'(1'b0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
